mips_trace_capture: RTL and testbench

- Sink for the processor's observation outputs (pc_out, alu_result).
- Detects each new PC value, captures a {pc, alu_result} record into a FIFO, and drains it as a byte stream over a valid/ready handshake.
- Sits beside mips_processor in the bench and at FPGA top-level, feeding a UART or trace port in place of $display logging.

---
 rtl/mips_trace_capture.sv | 207 ++++++++++++++++++++
 tb/tb_mips_trace_capture.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : mips_trace_capture
// Purpose  : Captures {pc, alu_result} records on every new PC value into a
//            small FIFO and drains them as an MSB-first byte stream over a
//            valid/ready handshake.
// Option   : TRACE_TIMESTAMP_EN -- prefixes each record with a 16-bit cycle
//            timestamp (two extra bytes, sent first).
// Revision : 1.0 - initial release
// ============================================================================
module mips_trace_capture #(
    parameter int PC_WIDTH   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            trace_en,
    input  logic [PC_WIDTH-1:0]             pc_in,
    input  logic [DATA_WIDTH-1:0]           alu_in,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    output logic [7:0]                      drop_count,
    input  logic                            clr_overflow
);

`ifdef TRACE_TIMESTAMP_EN
    localparam int c_TS_W = 16;
`else
    localparam int c_TS_W = 0;
`endif
    localparam int c_REC_W = c_TS_W + PC_WIDTH + DATA_WIDTH;
    localparam int c_NB    = c_REC_W / 8;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_IDX_W = $clog2(c_NB);

    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NB - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    // Capture tracking
    logic                   r_first;
    logic [PC_WIDTH-1:0]    r_prev_pc;
    logic                   w_capture;
    logic [c_REC_W-1:0]     w_record;

    // Record FIFO
    logic [c_REC_W-1:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   w_full;
    logic                   w_not_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;

    // Serializer
    logic [0:0]             r_state;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_REC_W-1:0]     r_shift;
    logic                   w_handshake;
    logic                   w_last;

    // Overflow bookkeeping
    logic                   r_overflow;
    logic [7:0]             r_drop_count;

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]            r_ts;

    // Free-running cycle counter; its value at the capture edge tags the record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 16'd1;
        end
    end

    assign w_record = {r_ts, pc_in, alu_in};
`else
    assign w_record = {pc_in, alu_in};
`endif

    assign w_capture   = trace_en && (r_first || (pc_in != r_prev_pc));
    assign w_full      = (r_count == c_FULL);
    assign w_not_empty = (r_count != '0);
    assign w_handshake = (r_state == c_SEND) && tx_ready;
    assign w_last      = (r_idx == c_LAST);
    // Pop either to start from idle or to chain the next record with no bubble
    assign w_pop       = w_not_empty &&
                         ((r_state == c_IDLE) || (w_handshake && w_last));
    // A same-edge pop frees a slot, so a full FIFO can still accept the push
    assign w_push      = w_capture && (!w_full || w_pop);
    assign w_drop      = w_capture && w_full && !w_pop;

    // New-PC detection: first_flag re-arms whenever tracing is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first   <= 1'b1;
            r_prev_pc <= '0;
        end else if (!trace_en) begin
            r_first   <= 1'b1;
        end else if (w_capture) begin
            r_first   <= 1'b0;
            r_prev_pc <= pc_in;
        end
    end

    // FIFO storage (data only; validity is tracked by the pointers/count)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_record;
        end
    end

    // FIFO pointers wrap naturally at the power-of-2 depth; count tells full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer FSM: shift register presents the current byte in its top 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_idx   <= '0;
                        r_state <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (w_handshake) begin
                        if (!w_last) begin
                            r_shift <= r_shift << 8;
                            r_idx   <= r_idx + c_IDX_W'(1);
                        end else if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_idx   <= '0;
                        end else begin
                            r_idx   <= '0;
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_overflow) begin
                r_drop_count <= 8'd1;
            end else if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end else if (clr_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign tx_data    = r_shift[c_REC_W-1 -: 8];
    assign tx_valid   = (r_state == c_SEND);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_trace_capture
// Purpose  : Self-checking bench for mips_trace_capture (default build:
//            16-bit PC, 16-bit data, 8-entry FIFO, no timestamp).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_trace_capture;

    logic        clk;
    logic        rst_n;
    logic        trace_en;
    logic [15:0] pc_in;
    logic [15:0] alu_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clr_overflow;

    int tests;
    int fails;

    // Expected byte stream, filled by the capture model, drained by the monitor
    logic [7:0] exp_q[$];
    logic        m_first;
    logic [15:0] m_prev;

    typedef struct {
        logic        en;
        logic [15:0] pc;
        logic [15:0] alu;
        logic        vld;
        logic [7:0]  data;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[11];

    mips_trace_capture #(
        .PC_WIDTH   (16),
        .DATA_WIDTH (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_en     (trace_en),
        .pc_in        (pc_in),
        .alu_in       (alu_in),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a byte valid with ready at the falling edge is taken at the next rising edge
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL stream: unexpected byte 0x%02h, expected none", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    fails++;
                    $display("FAIL stream: got 0x%02h, expected 0x%02h", tx_data, e);
                end
            end
        end
    end

    // Capture model: mirrors the new-PC rule and queues the expected bytes
    task automatic model(input logic en, input logic [15:0] pc, input logic [15:0] alu,
                         input logic keep);
        if (en) begin
            if (m_first || pc != m_prev) begin
                if (keep) begin
                    exp_q.push_back(pc[15:8]);
                    exp_q.push_back(pc[7:0]);
                    exp_q.push_back(alu[15:8]);
                    exp_q.push_back(alu[7:0]);
                end
                m_prev  = pc;
                m_first = 1'b0;
            end
        end else begin
            m_first = 1'b1;
        end
    endtask

    // One clock: drive inputs, update model, wait for the edge, settle
    task automatic step(input logic en, input logic [15:0] pc, input logic [15:0] alu,
                        input logic rdy, input logic clr, input logic keep);
        trace_en     = en;
        pc_in        = pc;
        alu_in       = alu;
        tx_ready     = rdy;
        clr_overflow = clr;
        model(en, pc, alu, keep);
        @(posedge clk);
        #1;
    endtask

    // Drain everything with tracing off; bounded wait
    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, pc_in, alu_in, 1'b1, 1'b0, 1'b0);
            if (exp_q.size() == 0 && !tx_valid && fifo_count == 4'd0) begin
                done = 1'b1;
                break;
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s: drain timeout, %0d bytes still expected, fifo_count %0d",
                     name, exp_q.size(), fifo_count);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        m_first      = 1'b1;
        m_prev       = 16'h0000;
        rst_n        = 1'b0;
        trace_en     = 1'b0;
        pc_in        = 16'h0000;
        alu_in       = 16'h0000;
        tx_ready     = 1'b0;
        clr_overflow = 1'b0;

        //             en    pc        alu       vld   data   cnt
        vecs[0]  = '{1'b1, 16'h0000, 16'h1111, 1'b0, 8'h00, 4'd1};
        vecs[1]  = '{1'b1, 16'h0002, 16'h1234, 1'b1, 8'h00, 4'd1};
        vecs[2]  = '{1'b1, 16'h0002, 16'h1234, 1'b1, 8'h00, 4'd1};
        vecs[3]  = '{1'b1, 16'h0002, 16'h1234, 1'b1, 8'h11, 4'd1};
        vecs[4]  = '{1'b1, 16'h0002, 16'h1234, 1'b1, 8'h11, 4'd1};
        vecs[5]  = '{1'b1, 16'h0002, 16'h1234, 1'b1, 8'h00, 4'd0};
        vecs[6]  = '{1'b1, 16'h0002, 16'h1234, 1'b1, 8'h02, 4'd0};
        vecs[7]  = '{1'b1, 16'h0002, 16'h1234, 1'b1, 8'h12, 4'd0};
        vecs[8]  = '{1'b1, 16'h0002, 16'h1234, 1'b1, 8'h34, 4'd0};
        vecs[9]  = '{1'b1, 16'h0002, 16'h1234, 1'b0, 8'h00, 4'd0};
        vecs[10] = '{1'b1, 16'h0002, 16'h1234, 1'b0, 8'h00, 4'd0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset tx_valid",   {31'd0, tx_valid}, 32'd0);
        chk("reset tx_data",    {24'd0, tx_data},  32'd0);
        chk("reset fifo_count", {28'd0, fifo_count}, 32'd0);
        chk("reset overflow",   {31'd0, overflow}, 32'd0);
        chk("reset drop_count", {24'd0, drop_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic record stream, cycle by cycle
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].en, vecs[i].pc, vecs[i].alu, 1'b1, 1'b0, 1'b1);
            chk($sformatf("basic[%0d] tx_valid", i), {31'd0, tx_valid}, {31'd0, vecs[i].vld});
            if (vecs[i].vld) begin
                chk($sformatf("basic[%0d] tx_data", i), {24'd0, tx_data}, {24'd0, vecs[i].data});
            end
            chk($sformatf("basic[%0d] fifo_count", i), {28'd0, fifo_count}, {28'd0, vecs[i].cnt});
        end
        drain("basic");

        // Stall on the second byte
        step(1'b1, 16'h00A4, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h00A4, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h00A4, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h00A4, 16'hBEEF, 1'b0, 1'b0, 1'b1);
            chk($sformatf("stall[%0d] tx_valid", i), {31'd0, tx_valid}, 32'd1);
            chk($sformatf("stall[%0d] tx_data", i), {24'd0, tx_data}, 32'h0000_00A4);
        end
        drain("stall");

        // Overflow: 12 distinct PCs with the sink stalled, then drive to saturation
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 16'h0A00 + 16'(i), 1'b0, 1'b0, (i < 9));
        end
        chk("ovf fifo_count", {28'd0, fifo_count}, 32'd8);
        chk("ovf overflow",   {31'd0, overflow},   32'd1);
        chk("ovf drop_count", {24'd0, drop_count}, 32'd3);
        for (int i = 12; i < 270; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 16'h0A00, 1'b0, 1'b0, 1'b0);
        end
        chk("ovf saturate", {24'd0, drop_count}, 32'd255);
        step(1'b1, 16'h0FFF, 16'h0A00, 1'b0, 1'b1, 1'b0);
        chk("clr+drop overflow",   {31'd0, overflow},   32'd1);
        chk("clr+drop drop_count", {24'd0, drop_count}, 32'd1);
        step(1'b0, 16'h0FFF, 16'h0A00, 1'b0, 1'b1, 1'b0);
        chk("clr overflow",   {31'd0, overflow},   32'd0);
        chk("clr drop_count", {24'd0, drop_count}, 32'd0);
        drain("overflow");

        // Full FIFO with pop and push on the same edge
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 16'h0200 + 16'(i), 16'hC000 + 16'(i), 1'b0, 1'b0, 1'b1);
        end
        chk("full fifo_count", {28'd0, fifo_count}, 32'd8);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0208, 16'hC008, 1'b1, 1'b0, 1'b1);
        end
        step(1'b1, 16'h0300, 16'hD000, 1'b1, 1'b0, 1'b1);
        chk("popush fifo_count", {28'd0, fifo_count}, 32'd8);
        chk("popush overflow",   {31'd0, overflow},   32'd0);
        chk("popush drop_count", {24'd0, drop_count}, 32'd0);
        drain("popush");

        // Repeated PC, then disable/re-enable
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'h0010, 16'h5555, 1'b1, 1'b0, 1'b1);
        end
        step(1'b0, 16'h0010, 16'h5555, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0010, 16'h5555, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h0010, 16'h6666, 1'b1, 1'b0, 1'b1);
        end
        drain("repeat");

        // Reset in the middle of a record
        step(1'b1, 16'h0ABC, 16'hDEF0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h0ABC, 16'hDEF0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h0ABC, 16'hDEF0, 1'b1, 1'b0, 1'b1);
        chk("pre-reset tx_data", {24'd0, tx_data}, 32'h0000_00BC);
        #1;
        rst_n    = 1'b0;
        trace_en = 1'b0;
        #1;
        chk("rst tx_valid",   {31'd0, tx_valid},   32'd0);
        chk("rst fifo_count", {28'd0, fifo_count}, 32'd0);
        exp_q.delete();
        m_first = 1'b1;
        m_prev  = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 16'h0ABC, 16'hDEF0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h0ABC, 16'hDEF0, 1'b1, 1'b0, 1'b1);
        chk("post-reset tx_valid", {31'd0, tx_valid}, 32'd1);
        chk("post-reset byte0",    {24'd0, tx_data},  32'h0000_000A);
        drain("reset");

        chk("leftover bytes", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
